// File: rtl/issue_controller_pkg.sv
// Shared opcode constants, RoB id width and IQ entry type for the issue path.
package issue_controller_pkg;

    localparam int ROB_SIZE_WIDTH = 4;

    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] JALR    = 7'b1100111;
    localparam logic [6:0] B_TYPE  = 7'b1100011;
    localparam logic [6:0] LD_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;
    localparam logic [6:0] I_TYPE  = 7'b0010011;
    localparam logic [6:0] R_TYPE  = 7'b0110011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
    } iq_entry_t;

    typedef enum logic {
        TGT_RS  = 1'b0,
        TGT_LSB = 1'b1
    } issue_tgt_e;

    // Only loads and stores go to the LSB; everything else, unknown opcodes included, goes to RS.
    function automatic issue_tgt_e route_of(input logic [6:0] opcode);
        return (opcode == LD_TYPE || opcode == S_TYPE) ? TGT_LSB : TGT_RS;
    endfunction

endpackage

// File: rtl/issue_queue.sv
// Circular instruction FIFO with push/pop/clear; the head reads as zero when the queue is empty.
import issue_controller_pkg::*;

module issue_queue #(
    parameter int DEPTH_W = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  iq_entry_t push_entry,
    input  logic      pop,
    input  logic      clear,
    output iq_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int DEPTH = 1 << DEPTH_W;

    iq_entry_t              mem [DEPTH];
    logic [DEPTH_W-1:0]     head_ptr;
    logic [DEPTH_W-1:0]     tail_ptr;
    logic [DEPTH_W:0]       count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty masks the head until a push lands.
    always_ff @(posedge clk) begin
        if (push) mem[tail_ptr] <= push_entry;
    end

    assign full  = (count == (DEPTH_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = empty ? '0 : mem[head_ptr];

endmodule

// File: rtl/issue_controller.sv
// IQ between Fetcher and Decoder: buffers fetches, routes the head to RS or LSB and tags it with a RoB id.
// Optional ISSUE_STALL_CNT_EN adds a saturating stall_cycles counter.
import issue_controller_pkg::*;

module issue_controller #(
    parameter int IQ_DEPTH_WIDTH = 2,
    parameter int ROB_ID_W       = ROB_SIZE_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                fetch_valid,
    input  logic [31:0]         fetch_instr,
    input  logic [31:0]         fetch_addr,
    output logic                fetch_ready,
    input  logic                rob_full,
    input  logic                rs_full,
    input  logic                lsb_full,
    input  logic [ROB_ID_W-1:0] rob_tail_id,
    input  logic                flush,
    output logic                dec_valid,
    output logic [31:0]         dec_instr,
    output logic [31:0]         dec_instr_addr,
    output logic                instr_issued,
    output logic                issue_to_rs,
    output logic                issue_to_lsb,
    output logic [ROB_ID_W-1:0] issue_rob_id
`ifdef ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]         stall_cycles
`endif
);

    iq_entry_t  head;
    iq_entry_t  push_entry;
    logic       full;
    logic       empty;
    logic       push;
    logic       fire;
    logic       tgt_is_lsb;
    logic       tgt_full;

    assign push_entry = '{instr: fetch_instr, addr: fetch_addr};

    // Ready depends only on registered occupancy, never on this cycle's pop.
    assign fetch_ready = !rst && !full;
    assign push        = fetch_valid && fetch_ready && rdy && !flush;

    issue_queue #(
        .DEPTH_W (IQ_DEPTH_WIDTH)
    ) u_iq (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (fire),
        .clear      (flush),
        .head       (head),
        .full       (full),
        .empty      (empty)
    );

    assign dec_valid      = !empty;
    assign dec_instr      = head.instr;
    assign dec_instr_addr = head.addr;

    assign tgt_is_lsb = (route_of(head.instr[6:0]) == TGT_LSB);
    // Strict in-order: a full target stalls the head even if the other unit has room.
    assign tgt_full   = tgt_is_lsb ? lsb_full : rs_full;
    assign fire       = dec_valid && rdy && !flush && !rob_full && !tgt_full;

    assign instr_issued = fire;
    assign issue_to_rs  = fire && !tgt_is_lsb;
    assign issue_to_lsb = fire && tgt_is_lsb;
    assign issue_rob_id = fire ? rob_tail_id : '0;

`ifdef ISSUE_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (rdy && dec_valid && !fire && !flush && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_issue_controller.sv
// Directed bench for issue_controller: hand-computed expectations for push, issue, routing, blocking, flush and rdy.
module tb_issue_controller;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        rob_full;
    logic        rs_full;
    logic        lsb_full;
    logic [3:0]  rob_tail_id;
    logic        flush;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_instr_addr;
    logic        instr_issued;
    logic        issue_to_rs;
    logic        issue_to_lsb;
    logic [3:0]  issue_rob_id;
`ifdef ISSUE_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int errs;
    int nchk;

    issue_controller dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .fetch_valid    (fetch_valid),
        .fetch_instr    (fetch_instr),
        .fetch_addr     (fetch_addr),
        .fetch_ready    (fetch_ready),
        .rob_full       (rob_full),
        .rs_full        (rs_full),
        .lsb_full       (lsb_full),
        .rob_tail_id    (rob_tail_id),
        .flush          (flush),
        .dec_valid      (dec_valid),
        .dec_instr      (dec_instr),
        .dec_instr_addr (dec_instr_addr),
        .instr_issued   (instr_issued),
        .issue_to_rs    (issue_to_rs),
        .issue_to_lsb   (issue_to_lsb),
        .issue_rob_id   (issue_rob_id)
`ifdef ISSUE_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] addr);
        fetch_valid = 1'b1;
        fetch_instr = instr;
        fetch_addr  = addr;
        tick();
        fetch_valid = 1'b0;
    endtask

    initial begin
        errs = 0;
        nchk = 0;
        rst = 1'b1; rdy = 1'b1; fetch_valid = 1'b0; fetch_instr = '0; fetch_addr = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rob_tail_id = '0; flush = 1'b0;

        // Reset state
        settle();
        check("rst_fetch_ready", 32'(fetch_ready), 32'd0);
        check("rst_dec_valid", 32'(dec_valid), 32'd0);
        check("rst_issued", 32'(instr_issued), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check("post_rst_fetch_ready", 32'(fetch_ready), 32'd1);
        check("post_rst_dec_instr", dec_instr, 32'd0);

        // Single addi issues to RS the cycle after push
        fetch_valid = 1'b1; fetch_instr = 32'h0050_0093; fetch_addr = 32'h0; rob_tail_id = 4'd3;
        settle();
        check("no_passthrough", 32'(dec_valid), 32'd0);
        tick();
        fetch_valid = 1'b0;
        settle();
        check("addi_valid", 32'(dec_valid), 32'd1);
        check("addi_instr", dec_instr, 32'h0050_0093);
        check("addi_issued", 32'(instr_issued), 32'd1);
        check("addi_to_rs", 32'(issue_to_rs), 32'd1);
        check("addi_to_lsb", 32'(issue_to_lsb), 32'd0);
        check("addi_rob_id", 32'(issue_rob_id), 32'd3);
        tick();
        settle();
        check("addi_popped", 32'(dec_valid), 32'd0);

        // lw blocked by lsb_full for 3 cycles, issues to LSB when it drops
        lsb_full = 1'b1; rob_tail_id = 4'd7;
        push_one(32'h0000_A103, 32'h4);
        for (int i = 0; i < 3; i++) begin
            settle();
            check("lw_blocked", 32'(instr_issued), 32'd0);
            check("lw_held", dec_instr, 32'h0000_A103);
            check("lw_rob_id_zero", 32'(issue_rob_id), 32'd0);
            tick();
        end
        lsb_full = 1'b0;
        settle();
        check("lw_issued", 32'(instr_issued), 32'd1);
        check("lw_to_lsb", 32'(issue_to_lsb), 32'd1);
        check("lw_to_rs", 32'(issue_to_rs), 32'd0);
        check("lw_rob_id", 32'(issue_rob_id), 32'd7);
        tick();

        // rob_full: 5 back-to-back offers, 4 accepted, then in-order drain
        rob_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            fetch_valid = 1'b1;
            fetch_instr = 32'h0010_0093 + (32'(i) << 20);
            fetch_addr  = 32'h10 + 32'(4 * i);
            settle();
            check("fill_ready", 32'(fetch_ready), (i < 4) ? 32'd1 : 32'd0);
            check("fill_no_issue", 32'(instr_issued), 32'd0);
            tick();
        end
        fetch_valid = 1'b0;
        rob_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("drain_issued", 32'(instr_issued), 32'd1);
            check("drain_addr", dec_instr_addr, 32'h10 + 32'(4 * i));
            check("drain_instr", dec_instr, 32'h0010_0093 + (32'(i) << 20));
            tick();
        end
        settle();
        check("drain_empty", 32'(dec_valid), 32'd0);

        // Full queue: push offered with a pop is still rejected
        rob_full = 1'b1;
        for (int i = 0; i < 4; i++) push_one(32'h0000_0033, 32'h100 + 32'(4 * i));
        rob_full = 1'b0;
        fetch_valid = 1'b1; fetch_instr = 32'h0000_0033; fetch_addr = 32'h1F0;
        settle();
        check("full_ready", 32'(fetch_ready), 32'd0);
        check("full_pop", 32'(instr_issued), 32'd1);
        tick();
        fetch_valid = 1'b0;
        for (int i = 1; i < 4; i++) begin
            settle();
            check("full_drain_addr", dec_instr_addr, 32'h100 + 32'(4 * i));
            tick();
        end
        settle();
        check("full_reject_dropped", 32'(dec_valid), 32'd0);

        // count=2, push and pop together keep count at 2
        rob_full = 1'b1;
        push_one(32'h0000_0033, 32'h200);
        push_one(32'h0000_0033, 32'h204);
        rob_full = 1'b0;
        fetch_valid = 1'b1; fetch_instr = 32'h0000_0033; fetch_addr = 32'h208;
        settle();
        check("pp_issue_a", dec_instr_addr, 32'h200);
        tick();
        fetch_valid = 1'b0;
        settle();
        check("pp_issue_b", dec_instr_addr, 32'h204);
        tick();
        settle();
        check("pp_issue_c", dec_instr_addr, 32'h208);
        check("pp_c_valid", 32'(instr_issued), 32'd1);
        tick();
        settle();
        check("pp_empty", 32'(dec_valid), 32'd0);

        // Flush with two queued entries and a concurrent fetch
        rob_full = 1'b1;
        push_one(32'h0000_0033, 32'h300);
        push_one(32'h0000_0033, 32'h304);
        rob_full = 1'b0; flush = 1'b1;
        fetch_valid = 1'b1; fetch_instr = 32'h0000_0013; fetch_addr = 32'h308;
        settle();
        check("flush_no_issue", 32'(instr_issued), 32'd0);
        tick();
        flush = 1'b0; fetch_valid = 1'b0;
        settle();
        check("flush_empty", 32'(dec_valid), 32'd0);
        check("flush_ready", 32'(fetch_ready), 32'd1);
        tick();
        settle();
        check("flush_dropped", 32'(dec_valid), 32'd0);

        // Reset mid-run, then rdy-low hold and stall counting under rs_full
        rst = 1'b1;
        settle();
`ifdef ISSUE_STALL_CNT_EN
        check("stall_rst", stall_cycles, 32'd0);
`endif
        tick();
        rst = 1'b0;
        rob_full = 1'b1; rob_tail_id = 4'd9;
        push_one(32'h0000_0033, 32'h400);
        rob_full = 1'b0; rdy = 1'b0;
        fetch_valid = 1'b1; fetch_instr = 32'h0000_0013; fetch_addr = 32'h404;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("rdy_no_issue", 32'(instr_issued), 32'd0);
            check("rdy_valid", 32'(dec_valid), 32'd1);
            check("rdy_head", dec_instr_addr, 32'h400);
`ifdef ISSUE_STALL_CNT_EN
            check("rdy_stall_hold", stall_cycles, 32'd0);
`endif
            tick();
        end
        fetch_valid = 1'b0; rdy = 1'b1; rs_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("rs_full_block", 32'(instr_issued), 32'd0);
`ifdef ISSUE_STALL_CNT_EN
            check("stall_count", stall_cycles, 32'(i));
`endif
            tick();
        end
        rs_full = 1'b0;
        settle();
        check("rdy_issue", 32'(issue_to_rs), 32'd1);
        check("rdy_rob_id", 32'(issue_rob_id), 32'd9);
`ifdef ISSUE_STALL_CNT_EN
        check("stall_final", stall_cycles, 32'd2);
`endif
        tick();
        settle();
        check("rdy_push_dropped", 32'(dec_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
